// File: rtl/ps2_mouse_packet_decoder_pkg.sv
// Shared definitions for the PS/2 mouse packet decoder: FSM state encoding and
// the bit positions of the fields carried in the first byte of every packet.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        S_B0 = 2'd0,
        S_B1 = 2'd1,
        S_B2 = 2'd2
    } state_t;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    localparam int VEL_W = 9;

endpackage

// File: rtl/ps2_mouse_packet_decoder_if.sv
// Byte stream in from the PS/2 receiver, decoded packet fields out to the cursor mover.
interface ps2_mouse_packet_decoder_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       pkt_valid;
    logic       btn_left;
    logic       btn_right;
    logic       btn_middle;
    logic [8:0] vel_x;
    logic [8:0] vel_y;
    logic       dir_x;
    logic       dir_y;
    logic       sync_err;

    modport master (
        output byte_valid, byte_data,
        input  pkt_valid, btn_left, btn_right, btn_middle,
        input  vel_x, vel_y, dir_x, dir_y, sync_err
    );

    modport slave (
        input  byte_valid, byte_data,
        output pkt_valid, btn_left, btn_right, btn_middle,
        output vel_x, vel_y, dir_x, dir_y, sync_err
    );
endinterface

// File: rtl/ps2_mouse_packet_decoder_delta_to_vel.sv
// Converts one 9-bit two's-complement PS/2 movement delta (plus overflow flag)
// into a scaled speed and a direction bit.
module ps2_delta_to_vel #(
    parameter int SHIFT = 1
) (
    input  logic       sign,
    input  logic       ovf,
    input  logic [7:0] data,
    output logic [8:0] vel,
    output logic       dir
);

    logic [8:0] delta;
    logic [8:0] mag;

    assign delta = {sign, data};

    // -256 negates onto itself in 9 bits, which is exactly the 256 magnitude we want
    always_comb begin
        mag = delta;
        if (ovf) begin
            mag = 9'd256;
        end else if (sign) begin
            mag = ~delta + 9'd1;
        end
    end

    assign vel = mag >> SHIFT;
    assign dir = ~sign;

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets, decodes buttons/speed/direction, and
// resyncs or zeroes velocity when the byte stream goes quiet.
module ps2_mouse_packet_decoder
    import ps2_mouse_pkg::*;
#(
    parameter int SHIFT          = 1,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input logic                        clk,
    input logic                        rstn,
    ps2_mouse_packet_decoder_if.slave  bus
);

    localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

    state_t             state_reg, state_next;
    logic [7:0]         byte0_reg, byte1_reg;
    logic [IDLE_W-1:0]  idle_reg;
    logic               expire;
    logic               cap0, cap1, pkt_done, sync_bad;

    logic               pkt_valid_reg, sync_err_reg;
    logic               btn_left_reg, btn_right_reg, btn_middle_reg;
    logic [VEL_W-1:0]   vel_x_reg, vel_y_reg;
    logic               dir_x_reg, dir_y_reg;

    logic [1:0]         axis_sign, axis_ovf, axis_dir;
    logic [7:0]         axis_data [2];
    logic [VEL_W-1:0]   axis_vel [2];

    // A byte arriving in the expiry cycle takes priority over the timeout
    assign expire = !bus.byte_valid && (idle_reg == IDLE_MAX);

    always_comb begin
        state_next = state_reg;
        cap0       = 1'b0;
        cap1       = 1'b0;
        pkt_done   = 1'b0;
        sync_bad   = 1'b0;
        case (state_reg)
            S_B0: begin
                if (bus.byte_valid) begin
                    if (bus.byte_data[SYNC]) begin
                        cap0       = 1'b1;
                        state_next = S_B1;
                    end else begin
                        sync_bad = 1'b1;
                    end
                end
            end
            S_B1: begin
                if (bus.byte_valid) begin
                    cap1       = 1'b1;
                    state_next = S_B2;
                end else if (expire) begin
                    state_next = S_B0;
                end
            end
            S_B2: begin
                if (bus.byte_valid) begin
                    pkt_done   = byte0_reg[SYNC];
                    state_next = S_B0;
                end else if (expire) begin
                    state_next = S_B0;
                end
            end
            default: state_next = S_B0;
        endcase
    end

    // X decodes from the captured byte1, Y directly from byte2 as it arrives
    assign axis_sign    = {byte0_reg[YSIGN], byte0_reg[XSIGN]};
    assign axis_ovf     = {byte0_reg[YOVF],  byte0_reg[XOVF]};
    assign axis_data[0] = byte1_reg;
    assign axis_data[1] = bus.byte_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            ps2_delta_to_vel #(
                .SHIFT (SHIFT)
            ) u_conv (
                .sign (axis_sign[gi]),
                .ovf  (axis_ovf[gi]),
                .data (axis_data[gi]),
                .vel  (axis_vel[gi]),
                .dir  (axis_dir[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg      <= S_B0;
            byte0_reg      <= '0;
            byte1_reg      <= '0;
            idle_reg       <= '0;
            pkt_valid_reg  <= 1'b0;
            sync_err_reg   <= 1'b0;
            btn_left_reg   <= 1'b0;
            btn_right_reg  <= 1'b0;
            btn_middle_reg <= 1'b0;
            vel_x_reg      <= '0;
            vel_y_reg      <= '0;
            dir_x_reg      <= 1'b0;
            dir_y_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pkt_valid_reg <= pkt_done;
            sync_err_reg  <= sync_bad;
            if (bus.byte_valid) begin
                idle_reg <= '0;
            end else if (idle_reg != IDLE_MAX) begin
                idle_reg <= idle_reg + IDLE_W'(1);
            end
            if (cap0) byte0_reg <= bus.byte_data;
            if (cap1) byte1_reg <= bus.byte_data;
            if (pkt_done) begin
                btn_left_reg   <= byte0_reg[BTN_L];
                btn_right_reg  <= byte0_reg[BTN_R];
                btn_middle_reg <= byte0_reg[BTN_M];
                vel_x_reg      <= axis_vel[0];
                vel_y_reg      <= axis_vel[1];
                dir_x_reg      <= axis_dir[0];
                dir_y_reg      <= axis_dir[1];
            end else if (expire) begin
                vel_x_reg <= '0;
                vel_y_reg <= '0;
            end
        end
    end

    assign bus.pkt_valid  = pkt_valid_reg;
    assign bus.sync_err   = sync_err_reg;
    assign bus.btn_left   = btn_left_reg;
    assign bus.btn_right  = btn_right_reg;
    assign bus.btn_middle = btn_middle_reg;
    assign bus.vel_x      = vel_x_reg;
    assign bus.vel_y      = vel_y_reg;
    assign bus.dir_x      = dir_x_reg;
    assign bus.dir_y      = dir_y_reg;

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Scoreboard bench: stimulus thread runs a packet-level reference model and queues
// expectations; the monitor thread compares them against the decoder's outputs.
module tb_ps2_mouse_packet_decoder;

    localparam int SHIFT = 1;
    localparam int TO    = 100;

    typedef struct packed {
        logic       l;
        logic       r;
        logic       m;
        logic [8:0] vx;
        logic [8:0] vy;
        logic       dx;
        logic       dy;
    } out_t;

    typedef struct {
        int    due;
        out_t  v;
        string name;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t       exp_pkt[$];
    exp_t       exp_hold[$];
    int         exp_sync[$];
    logic [7:0] pend[$];
    out_t       m_out;
    int         low_run;

    ps2_mouse_packet_decoder_if bus();

    ps2_mouse_packet_decoder #(
        .SHIFT          (SHIFT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic out_t pk(logic l, logic r, logic m, int vx, int vy, logic dx, logic dy);
        out_t o;
        o.l = l; o.r = r; o.m = m;
        o.vx = 9'(vx); o.vy = 9'(vy);
        o.dx = dx; o.dy = dy;
        return o;
    endfunction

    // Packet meaning from first principles: signed 9-bit deltas, absolute value, scale
    function automatic out_t decode(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2);
        int dx, dy, mx, my;
        dx = b0[4] ? int'(b1) - 256 : int'(b1);
        dy = b0[5] ? int'(b2) - 256 : int'(b2);
        mx = b0[6] ? 256 : (dx < 0 ? -dx : dx);
        my = b0[7] ? 256 : (dy < 0 ? -dy : dy);
        return pk(b0[0], b0[1], b0[2], mx >> SHIFT, my >> SHIFT, dx >= 0, dy >= 0);
    endfunction

    function automatic out_t actual();
        out_t o;
        o = {bus.btn_left, bus.btn_right, bus.btn_middle, bus.vel_x, bus.vel_y, bus.dir_x, bus.dir_y};
        return o;
    endfunction

    function automatic void chk(string name, out_t v);
        exp_t e;
        e.due = cyc + 1; e.v = v; e.name = name;
        exp_hold.push_back(e);
    endfunction

    task automatic step(bit v, logic [7:0] d, bit r);
        exp_t e;
        @(negedge clk);
        rstn           = !r;
        bus.byte_valid = v;
        bus.byte_data  = d;
        if (r) begin
            pend.delete();
            m_out   = '0;
            low_run = 0;
        end else if (v) begin
            low_run = 0;
            if (pend.size() == 0 && !d[3]) begin
                exp_sync.push_back(cyc + 1);
            end else begin
                pend.push_back(d);
                if (pend.size() == 3) begin
                    m_out = decode(pend[0], pend[1], pend[2]);
                    e.due = cyc + 1; e.v = m_out; e.name = "pkt";
                    exp_pkt.push_back(e);
                    pend.delete();
                end
            end
        end else begin
            low_run++;
            if (low_run >= TO) begin
                pend.delete();
                m_out.vx = '0;
                m_out.vy = '0;
            end
        end
        if (!v || r) chk("hold", m_out);
    endtask

    task automatic send(logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 8'h00, 1'b0);
    endtask

    // Monitor: sole owner of the check/error counters
    initial begin
        exp_t e;
        out_t a;
        forever begin
            @(negedge clk);
            a = actual();
            if (bus.pkt_valid) begin
                checks++;
                if (exp_pkt.size() == 0) begin
                    errors++;
                    $display("FAIL pkt_valid: unexpected pulse at cycle %0d outputs %h, required no pulse", cyc, a);
                end else begin
                    e = exp_pkt.pop_front();
                    if (e.due != cyc || a !== e.v) begin
                        errors++;
                        $display("FAIL pkt: got %h at cycle %0d, required %h at cycle %0d", a, cyc, e.v, e.due);
                    end
                end
            end else if (exp_pkt.size() != 0 && exp_pkt[0].due <= cyc) begin
                checks++;
                errors++;
                e = exp_pkt.pop_front();
                $display("FAIL pkt_valid: no pulse at cycle %0d, required pulse with %h", cyc, e.v);
            end
            if (bus.sync_err) begin
                checks++;
                if (exp_sync.size() == 0 || exp_sync[0] != cyc) begin
                    errors++;
                    $display("FAIL sync_err: pulse at cycle %0d, required %0d pending", cyc, exp_sync.size());
                end
                if (exp_sync.size() != 0) void'(exp_sync.pop_front());
            end else if (exp_sync.size() != 0 && exp_sync[0] <= cyc) begin
                checks++;
                errors++;
                $display("FAIL sync_err: no pulse at cycle %0d, required pulse", cyc);
                void'(exp_sync.pop_front());
            end
            while (exp_hold.size() != 0 && exp_hold[0].due <= cyc) begin
                e = exp_hold.pop_front();
                checks++;
                if (e.due != cyc || a !== e.v) begin
                    errors++;
                    $display("FAIL %s: got %h at cycle %0d, required %h", e.name, a, cyc, e.v);
                end
            end
        end
    end

    initial begin
        int gaps[8] = '{1, 2, 5, 20, 98, 99, 100, 140};
        logic [7:0] b0;
        int kind, n;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        m_out   = '0;
        low_run = 0;

        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("reset", '0);
        idle(2);

        send(8'h29); send(8'h05); send(8'hFB);
        chk("t1", pk(1, 0, 0, 2, 2, 1, 0));
        idle(2);

        send(8'h02); send(8'h08); send(8'h10); send(8'h00);
        chk("t2", pk(0, 0, 0, 8, 0, 1, 1));
        idle(2);

        send(8'h18); send(8'h00); send(8'h00);
        chk("t3_neg256", pk(0, 0, 0, 128, 0, 0, 1));
        send(8'h48); send(8'h00); send(8'h00);
        chk("t3_xovf", pk(0, 0, 0, 128, 0, 1, 1));
        idle(2);

        send(8'h08); send(8'h10);
        idle(100);
        chk("t4_idle_clear", pk(0, 0, 0, 0, 0, 1, 1));
        send(8'h0A); send(8'h04); send(8'h06);
        chk("t4_resync", pk(0, 1, 0, 2, 3, 1, 1));
        idle(2);

        send(8'h09); send(8'h40); send(8'h40);
        chk("t5_pkt", pk(1, 0, 0, 32, 32, 1, 1));
        idle(100);
        chk("t5_vel_clear", pk(1, 0, 0, 0, 0, 1, 1));

        send(8'h08); send(8'h10);
        step(1'b0, 8'h00, 1'b1);
        chk("t6_reset", '0);
        send(8'h09); send(8'h02); send(8'h02);
        chk("t6_pkt", pk(1, 0, 0, 1, 1, 1, 1));

        send(8'h08); send(8'h20);
        idle(99);
        chk("t7_no_clear", pk(1, 0, 0, 1, 1, 1, 1));
        send(8'h04);
        chk("t7_byte_wins", pk(0, 0, 0, 16, 2, 1, 1));
        idle(2);

        for (int it = 0; it < 200; it++) begin
            kind = $urandom_range(0, 9);
            if (kind < 7) begin
                b0 = 8'($urandom) | 8'h08;
                if ($urandom_range(0, 3) != 0) b0[7:6] = 2'b00;
                send(b0);
                idle($urandom_range(0, 2));
                send(8'($urandom));
                idle($urandom_range(0, 2));
                send(8'($urandom));
            end else if (kind == 7) begin
                send(8'($urandom) & 8'hF7);
            end else if (kind == 8) begin
                n = $urandom_range(1, 2);
                repeat (n) send(8'($urandom) | 8'h08);
            end else begin
                idle(1);
                step(1'b0, 8'h00, 1'b1);
            end
            idle(gaps[$urandom_range(0, 7)]);
        end

        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
